// File: rtl/multi_seq.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations per operation,
// full 2*WIDTH-bit product plus truncated result and overflow flag.
module multi_seq #(
    parameter int WIDTH = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   res,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow,
    output logic               busy,
    output logic               done,
    output logic               state_dbg
);

    // Handshake: start is sampled on a rising edge only while busy=0; the
    // result is valid in the cycle done=1 and held until the next completion.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    assign state_dbg = (state == RUN);

    // Partial product for this iteration: multiplicand weighted by the bit index.
    always_comb begin
        addend   = '0;
        if (mplier[0]) begin
            addend = mcand << count;
        end
        acc_next = acc + addend;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            count    <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            res      <= '0;
            product  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    // Final iteration publishes the result in the same edge.
                    if (count == LAST) begin
                        product  <= acc_next;
                        res      <= acc_next[WIDTH-1:0];
                        overflow <= |acc_next[2*WIDTH-1:WIDTH];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_seq.sv
// Self-checking bench for multi_seq: directed cases plus random operands,
// scoreboard fed by the driver and drained by a done-triggered monitor.
module tb_multi_seq;

    localparam int W = 5;
    localparam int TIMEOUT = 100;

    logic              clock;
    logic              resetn;
    logic              start;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [W-1:0]      res;
    logic [2*W-1:0]    product;
    logic              overflow;
    logic              busy;
    logic              done;
    logic              state_dbg;

    logic [2*W-1:0]    exp_q[$];
    logic [2*W-1:0]    hold_prod;
    int                n_checks;
    int                n_fail;
    int                busy_len;
    logic              prev_busy;
    logic              prev_done;

    multi_seq #(.WIDTH(W)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .a        (a),
        .b        (b),
        .res      (res),
        .product  (product),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference values derived from plain multiplication.
    function automatic logic [W-1:0] model_res(input logic [2*W-1:0] p);
        return p[W-1:0];
    endfunction

    function automatic logic model_ovf(input logic [2*W-1:0] p);
        return (p >> W) != 0;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic [2*W-1:0] e;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        busy_len  = 0;
        hold_prod = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                check("reset_product", product, 0);
                check("reset_res", res, 0);
                check("reset_overflow", overflow, 0);
                check("reset_busy", busy, 0);
                check("reset_done", done, 0);
                hold_prod = '0;
                busy_len  = 0;
                prev_busy = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("product", product, e);
                        check("res", res, model_res(e));
                        check("overflow", overflow, model_ovf(e));
                        hold_prod = e;
                    end
                    if (prev_done) check("done_one_cycle", 1, 0);
                end else begin
                    check("hold_product", product, hold_prod);
                    check("hold_res", res, model_res(hold_prod));
                    check("hold_overflow", overflow, model_ovf(hold_prod));
                end
                if (busy) busy_len++;
                if (prev_busy && !busy) begin
                    check("busy_len", busy_len, W);
                    check("done_with_busy_fall", done, 1);
                    busy_len = 0;
                end
                prev_busy = busy;
                prev_done = done;
            end
        end
    end

    // Driver tasks
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        wait_idle();
        start = 1'b1;
        a     = av;
        b     = bv;
        exp_q.push_back((2*W)'(av) * (2*W)'(bv));
        @(posedge clock);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b1;
        a      = 5'd7;
        b      = 5'd9;
        n_checks = 0;
        n_fail   = 0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        start  = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("idle_after_reset_busy", busy, 0);
        end

        // Directed cases
        issue(5'd2, 5'd0);
        issue(5'd3, 5'd7);
        issue(5'd31, 5'd31);
        issue(5'd4, 5'd8);
        issue(5'd0, 5'd31);
        drain();

        // Start during RUN with new operands must be ignored.
        issue(5'd3, 5'd7);
        @(negedge clock);
        start = 1'b1;
        a     = 5'd31;
        b     = 5'd31;
        repeat (2) @(negedge clock);
        start = 1'b0;
        drain();

        // Reset mid-run: abort with no done pulse, outputs clear immediately.
        issue(5'd31, 5'd31);
        @(posedge clock);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_product", product, 0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("no_done_after_abort", done, 0);
        end
        issue(5'd6, 5'd5);
        drain();

        // Random back-to-back traffic (wait_idle releases in the done cycle).
        for (int i = 0; i < 60; i++) begin
            issue(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
